fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Sequential PC register and instruction-fetch stage that sits directly downstream of the next-PC combinational block.
- Drives the current `pc` to the next-PC block and latches its `next_pc` result when the core retires an instruction.
- Fetches the instruction at `pc` over a req/gnt + rvalid memory handshake.
- Presents the instruction to decode over a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FETCH_W, 32, instruction/address width (fixed 32; parameter exists for package consistency only).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on clk edge)
- next_pc  in  32  target PC from the next-PC block
- pc_we  in  1  retire strobe; load next_pc into pc and start a new fetch
- pc  out  32  current PC; feeds the next-PC block PC input
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (equals pc)
- imem_gnt  in  1  request accepted
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- instr  out  32  fetched instruction to decode
- instr_valid  out  1  instr holds valid data
- instr_ready  in  1  decode accepts instr
- misaligned  out  1  sticky: pc_we carried next_pc[1:0]!=0
- protocol_err  out  1  sticky: pc_we received in an illegal state
- perf_fetch_cnt  out  32  completed fetches (optional feature)
- perf_stall_cnt  out  32  stall cycles (optional feature)

Behaviour:
- Reset values:
  - pc=RESET_PC, state=FETCH.
  - imem_req=0 during the reset cycle.
  - instr=0, instr_valid=0, misaligned=0, protocol_err=0, counters=0.
- States and transitions:
  - FETCH: imem_req=1, imem_addr=pc.
    - On imem_gnt: go to WAIT.
    - If imem_gnt and imem_rvalid are both high in the same cycle (zero-latency memory): capture the data and go straight to VALID.
  - WAIT: imem_req=0. On imem_rvalid: instr<=imem_rdata, instr_valid<=1, go to VALID.
  - VALID: instr_valid=1; instr stable until handshake.
    - On instr_valid & instr_ready: instr_valid<=0, go to DONE.
    - If pc_we is high in the same cycle as the handshake: pc<=next_pc, go to FETCH.
  - DONE: wait for pc_we, then pc<=next_pc and go to FETCH.
  - HALT: entered when pc_we carries next_pc[1:0]!=0.
    - pc is still loaded, misaligned<=1, no further requests.
    - Leaves HALT only on reset.
- pc_we handling:
  - Honoured only in DONE, or in VALID coincident with the handshake.
  - Anywhere else pc_we is ignored, pc is unchanged, and protocol_err<=1 (sticky).
- imem_rvalid arriving in FETCH, DONE or HALT (no outstanding request) is ignored. This covers stale responses after a mid-fetch reset.
- Reset mid-operation: the outstanding request is abandoned, instr_valid drops the next cycle, and fetching restarts at RESET_PC.
- Latency: minimum 1 cycle from pc_we to imem_req; minimum 1 cycle from rvalid to instr_valid (0 extra cycles when gnt and rvalid coincide).
- pc is purely registered; it changes only on pc_we or reset.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetch_cnt increments on each VALID-entry.
  - perf_stall_cnt increments every cycle in FETCH with imem_gnt=0, or in VALID with instr_ready=0.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: counter logic is not built; both ports tie to 0.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum (FETCH, WAIT, VALID, DONE, HALT).
  - RESET_PC default.
  - Branch-select encoding constants shared with the next-PC block: BR_SEQ=0, BR_JAL=1, BR_JALR=2, BR_BEQ=4, BR_BNE=5, BR_BLT=6, BR_BGE=7.
- Sub-module fetch_perf_cnt: the two counters, instantiated only under FETCH_PERF_CNT_EN.

Test Plan:
- Reset release, memory grants immediately, rvalid 2 cycles later with rdata=32'h00000013 -> imem_addr=0, instr=32'h00000013, instr_valid=1, pc=0.
- Decode ready, pc_we with next_pc=32'h0000_0040 coincident with handshake -> next cycle pc=0x40, imem_req=1, imem_addr=0x40.
- gnt and rvalid high in the same cycle -> VALID entered the next cycle; no WAIT cycle.
- instr_ready held low for 5 cycles -> instr stable, instr_valid=1 throughout; perf_stall_cnt=5 with FETCH_PERF_CNT_EN.
- pc_we with next_pc=32'h0000_0042 -> misaligned=1, state HALT, imem_req stays 0 until reset.
- Reset asserted in WAIT, stale rvalid arrives the cycle after reset releases -> rvalid ignored, new fetch at RESET_PC; pc_we in FETCH -> protocol_err=1, pc unchanged.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the fetch stage and the
//               next-PC block (state encoding, reset PC, branch selects).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          FETCH_W_DEFAULT  = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Branch-select encoding understood by the next-PC block
    localparam logic [2:0] BR_SEQ  = 3'd0;
    localparam logic [2:0] BR_JAL  = 3'd1;
    localparam logic [2:0] BR_JALR = 3'd2;
    localparam logic [2:0] BR_BEQ  = 3'd4;
    localparam logic [2:0] BR_BNE  = 3'd5;
    localparam logic [2:0] BR_BLT  = 3'd6;
    localparam logic [2:0] BR_BGE  = 3'd7;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_WAIT  = 3'd1,
        ST_VALID = 3'd2,
        ST_DONE  = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : fetch_perf_cnt
// Description : Completed-fetch and stall-cycle counters for the fetch stage.
//               Both counters are 32-bit, free-running and wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_fetch,
    input  logic        inc_stall,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Next counter values
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (inc_fetch) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (inc_stall) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Counter registers, cleared by the active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC register and instruction-fetch stage. Fetches the word at
//               pc over req/gnt + rvalid, hands it to decode over valid/ready
//               and loads next_pc when the core retires an instruction.
//               Optional macro FETCH_PERF_CNT_EN builds the performance
//               counters; otherwise the counter ports are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 FETCH_W  = FETCH_W_DEFAULT,
    parameter logic [FETCH_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FETCH_W-1:0] next_pc,
    input  logic               pc_we,
    output logic [FETCH_W-1:0] pc,
    output logic               imem_req,
    output logic [FETCH_W-1:0] imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [FETCH_W-1:0] imem_rdata,
    output logic [FETCH_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               misaligned,
    output logic               protocol_err,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
);

    fetch_state_t       state_q, state_d;
    logic [FETCH_W-1:0] pc_q, pc_d;
    logic [FETCH_W-1:0] instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;
    logic               misaligned_q, misaligned_d;
    logic               protocol_err_q, protocol_err_d;

    logic               w_handshake;
    logic               w_pc_ok;

    // instr_valid_q is high exactly while in VALID, so it qualifies the handshake
    assign w_handshake = instr_valid_q & instr_ready;
    assign w_pc_ok     = (state_q == ST_DONE) || ((state_q == ST_VALID) && w_handshake);

    // Next-state, fetch capture and retire (pc_we) handling
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        instr_valid_d  = instr_valid_q;
        misaligned_d   = misaligned_q;
        protocol_err_d = protocol_err_q;

        case (state_q)
            ST_FETCH: begin
                if (imem_gnt) begin
                    if (imem_rvalid) begin
                        // Zero-latency memory: skip WAIT entirely
                        instr_d       = imem_rdata;
                        instr_valid_d = 1'b1;
                        state_d       = ST_VALID;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = ST_VALID;
                end
            end
            ST_VALID: begin
                if (w_handshake) begin
                    instr_valid_d = 1'b0;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase

        // Retire overrides the DONE transition; misaligned targets park in HALT
        if (pc_we) begin
            if (w_pc_ok) begin
                pc_d = next_pc;
                if (next_pc[1:0] != 2'b00) begin
                    misaligned_d = 1'b1;
                    state_d      = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end else begin
                protocol_err_d = 1'b1;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_FETCH;
            pc_q           <= RESET_PC;
            instr_q        <= '0;
            instr_valid_q  <= 1'b0;
            misaligned_q   <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            instr_valid_q  <= instr_valid_d;
            misaligned_q   <= misaligned_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    // Request is suppressed during the reset cycle itself
    assign imem_req     = reset && (state_q == ST_FETCH);
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign instr        = instr_q;
    assign instr_valid  = instr_valid_q;
    assign misaligned   = misaligned_q;
    assign protocol_err = protocol_err_q;

`ifdef FETCH_PERF_CNT_EN
    logic w_valid_entry;
    logic w_stall;

    assign w_valid_entry = (state_d == ST_VALID) && (state_q != ST_VALID);
    assign w_stall       = ((state_q == ST_FETCH) && !imem_gnt) ||
                           ((state_q == ST_VALID) && !instr_ready);

    fetch_perf_cnt u_perf (
        .clk       (clk),
        .reset     (reset),
        .inc_fetch (w_valid_entry),
        .inc_stall (w_stall),
        .fetch_cnt (perf_fetch_cnt),
        .stall_cnt (perf_stall_cnt)
    );
`else
    assign perf_fetch_cnt = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
